// File: rtl/nv_nvdla_cacc2sdp_buf.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cacc2sdp_buf
//
// Elastic buffer between the CACC output and the SDP partition input.
// Every element coming out of CACC is written into a small registered FIFO
// and presented to SDP from there, so SDP backpressure never reaches CACC
// through a combinational path. The upstream ready is a flop, and an element
// written on one edge is visible downstream only after that edge (there is
// no same-cycle bypass around the storage).
//
// Alongside the data path the block watches the end-of-batch and
// end-of-layer markers as elements are delivered to SDP, and keeps
// per-layer element and batch counters plus a one-cycle layer-done pulse
// for status and debug visibility.
//
// Payload format (34 bits, identical on both sides):
//   [31:0] data
//   [32]   batch_end
//   [33]   layer_end
//
// Ports:
//   nvdla_core_clk      in   core clock
//   nvdla_core_rst      in   asynchronous active-high reset
//   cacc2sdp_valid_in   in   upstream element valid
//   cacc2sdp_ready_out  out  upstream ready (registered)
//   cacc2sdp_pd_in      in   upstream payload
//   cacc2sdp_valid      out  downstream valid toward SDP
//   cacc2sdp_ready      in   downstream ready from SDP
//   cacc2sdp_pd         out  downstream payload (zero while empty)
//   buf_level           out  current FIFO occupancy, 0..DEPTH
//   elem_cnt            out  elements delivered in the current layer
//   batch_cnt           out  batch_end elements delivered in the current layer
//   layer_done          out  one-cycle pulse after a layer_end element leaves
//
// Parameters:
//   DEPTH   FIFO entries, power of two and at least 2
//   CNT_W   width of the per-layer element counter
//   BCNT_W  width of the per-layer batch counter
// ---------------------------------------------------------------------------
module nv_nvdla_cacc2sdp_buf #(
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 24,
   parameter int BCNT_W = 5
) (
   input  logic                     nvdla_core_clk,
   input  logic                     nvdla_core_rst,
   input  logic                     cacc2sdp_valid_in,
   output logic                     cacc2sdp_ready_out,
   input  logic [33:0]              cacc2sdp_pd_in,
   output logic                     cacc2sdp_valid,
   input  logic                     cacc2sdp_ready,
   output logic [33:0]              cacc2sdp_pd,
   output logic [$clog2(DEPTH):0]   buf_level,
   output logic [CNT_W-1:0]         elem_cnt,
   output logic [BCNT_W-1:0]        batch_cnt,
   output logic                     layer_done
);

   localparam int AW = $clog2(DEPTH);

   // DEPTH expressed in the occupancy width so the full comparison is
   // done at matching widths.
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [33:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_nxt;
   logic          in_acc;
   logic          out_acc;
   logic [33:0]   head_pd;

   // Handshake qualifiers. The upstream side only ever sees our registered
   // ready, so the input accept never depends on cacc2sdp_ready.
   assign in_acc  = cacc2sdp_valid_in & cacc2sdp_ready_out;
   assign out_acc = cacc2sdp_valid & cacc2sdp_ready;

   // The head of the FIFO is read straight from storage. Valid comes from
   // the registered occupancy, so a freshly written element appears only
   // after the edge that wrote it. The payload is forced to zero while
   // empty so nothing stale is ever presented, including right after reset.
   assign head_pd        = mem[rd_ptr];
   assign cacc2sdp_valid = (count != '0);
   assign cacc2sdp_pd    = cacc2sdp_valid ? head_pd : '0;
   assign buf_level      = count;

   // Next occupancy: a simultaneous push and pop leaves the level unchanged.
   always_comb begin
      count_nxt = count;
      case ({in_acc, out_acc})
         2'b10:   count_nxt = count + (AW+1)'(1);
         2'b01:   count_nxt = count - (AW+1)'(1);
         default: count_nxt = count;
      endcase
   end

   // Storage array. It carries no reset: the pointers and occupancy define
   // which entries are live, and the output mux hides anything left over
   // from before a reset.
   always_ff @(posedge nvdla_core_clk) begin
      if (in_acc) begin
         mem[wr_ptr] <= cacc2sdp_pd_in;
      end
   end

   // Pointer, occupancy and upstream-ready state. Pointers are AW bits wide
   // so they wrap modulo DEPTH on their own. Ready is computed from the
   // next occupancy and registered; this is why a pop at full only raises
   // ready on the following cycle, costing one cycle of throughput there.
   // Ready is held low for as long as reset is asserted.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
         cacc2sdp_ready_out <= 1'b0;
      end else begin
         if (in_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (out_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count              <= count_nxt;
         cacc2sdp_ready_out <= (count_nxt < DEPTH_L);
      end
   end

   // Per-layer bookkeeping, driven only by elements actually delivered to
   // SDP, so markers still sitting in the FIFO have no effect yet. A
   // layer_end element closes the layer: both counters restart from zero
   // (layer_end wins over batch_end on the same element) and layer_done
   // pulses for the cycle after delivery. Back-to-back layer_end
   // deliveries give back-to-back pulses because the pulse is recomputed
   // every cycle.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         elem_cnt   <= '0;
         batch_cnt  <= '0;
         layer_done <= 1'b0;
      end else begin
         layer_done <= out_acc & head_pd[33];
         if (out_acc) begin
            if (head_pd[33]) begin
               elem_cnt  <= '0;
               batch_cnt <= '0;
            end else begin
               elem_cnt <= elem_cnt + CNT_W'(1);
               if (head_pd[32]) begin
                  batch_cnt <= batch_cnt + BCNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_nv_nvdla_cacc2sdp_buf.sv
// ---------------------------------------------------------------------------
// tb_nv_nvdla_cacc2sdp_buf
//
// Directed bench for the CACC->SDP elastic buffer. The driver pushes each
// accepted element into an expected queue; an independent monitor pops and
// compares whenever SDP takes an element, and tracks the per-layer counters
// and layer-done pulse against a small model built from the expected
// payloads. Directed checks cover reset values, full/empty behaviour,
// streaming throughput, markers and reset in the middle of a stream.
// ---------------------------------------------------------------------------
module tb_nv_nvdla_cacc2sdp_buf;

   localparam int DEPTH  = 8;
   localparam int CNT_W  = 24;
   localparam int BCNT_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid_in;
   logic              ready_out;
   logic [33:0]       pd_in;
   logic              valid;
   logic              sdp_ready;
   logic [33:0]       pd;
   logic [3:0]        buf_level;
   logic [CNT_W-1:0]  elem_cnt;
   logic [BCNT_W-1:0] batch_cnt;
   logic              layer_done;

   nv_nvdla_cacc2sdp_buf #(
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W),
      .BCNT_W (BCNT_W)
   ) dut (
      .nvdla_core_clk     (clk),
      .nvdla_core_rst     (rst),
      .cacc2sdp_valid_in  (valid_in),
      .cacc2sdp_ready_out (ready_out),
      .cacc2sdp_pd_in     (pd_in),
      .cacc2sdp_valid     (valid),
      .cacc2sdp_ready     (sdp_ready),
      .cacc2sdp_pd        (pd),
      .buf_level          (buf_level),
      .elem_cnt           (elem_cnt),
      .batch_cnt          (batch_cnt),
      .layer_done         (layer_done)
   );

   // Free-running clock and a cycle counter used for latency measurements.
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard state and the bench's own model of the layer counters.
   logic [33:0]       exp_q[$];
   int                n_checks = 0;
   int                n_pass = 0;
   bit                monitor_en = 1'b0;
   logic [CNT_W-1:0]  m_elem = '0;
   logic [BCNT_W-1:0] m_batch = '0;
   logic              m_done = 1'b0;
   int                done_pulses = 0;
   int                max_level = 0;
   int                first_push = 0;
   int                last_pop = 0;
   bit                first_seen = 1'b0;
   bit                prev_stall = 1'b0;
   logic [33:0]       prev_pd = '0;

   // Single comparison point: every check steps the counters used by the
   // summary line.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Monitor: sampled on the falling edge, well away from the active edge.
   // An output accept seen here takes effect at the next rising edge, so
   // the model is advanced now and compared against the DUT one cycle on.
   always @(negedge clk) begin
      logic [33:0] e;
      if (monitor_en) begin
         checkOutput("elem_cnt", elem_cnt, m_elem);
         checkOutput("batch_cnt", batch_cnt, m_batch);
         checkOutput("layer_done", layer_done, m_done);
         checkOutput("valid_vs_level", valid, buf_level != 0);
         if (layer_done) done_pulses++;
         if (int'(buf_level) > max_level) max_level = int'(buf_level);
         if (prev_stall) begin
            checkOutput("hold_valid", valid, 1);
            checkOutput("hold_pd", pd, prev_pd);
         end
         m_done = 1'b0;
         if (valid && sdp_ready) begin
            last_pop = cyc;
            if (exp_q.size() == 0) begin
               checkOutput("stale_output", valid, 0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("pd_order", pd, e);
               if (e[33]) begin
                  m_elem  = '0;
                  m_batch = '0;
                  m_done  = 1'b1;
               end else begin
                  m_elem = m_elem + 1'b1;
                  if (e[32]) m_batch = m_batch + 1'b1;
               end
            end
         end
         prev_stall = valid && !sdp_ready;
         prev_pd    = pd;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one element upstream and hold it until accepted (bounded).
   // Returns 1 time unit after the accepting edge, so consecutive calls
   // keep valid_in high continuously.
   task automatic applyStimulus(input logic [31:0] data, input bit be, input bit le);
      int  waited;
      bit  done;
      waited   = 0;
      done     = 1'b0;
      valid_in = 1'b1;
      pd_in    = {le, be, data};
      while (!done) begin
         @(negedge clk);
         if (ready_out) begin
            exp_q.push_back(pd_in);
            if (!first_seen) begin
               first_push = cyc;
               first_seen = 1'b1;
            end
            done = 1'b1;
         end else begin
            waited++;
            if (waited > 200) begin
               checkOutput("accept_timeout", 0, 1);
               done = 1'b1;
            end
         end
         @(posedge clk);
         #1;
      end
      valid_in = 1'b0;
   endtask

   // Wait (bounded) until everything pushed has been delivered.
   task automatic drain();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || valid) && w < 300) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (w >= 300) checkOutput("drain_timeout", 0, 1);
   endtask

   task automatic clearModel();
      exp_q.delete();
      m_elem      = '0;
      m_batch     = '0;
      m_done      = 1'b0;
      prev_stall  = 1'b0;
      done_pulses = 0;
      max_level   = 0;
      first_seen  = 1'b0;
   endtask

   // Full reset sequence with checks of the values held during reset and
   // of ready rising on the first edge after release.
   task automatic resetDut();
      monitor_en = 1'b0;
      rst        = 1'b1;
      valid_in   = 1'b0;
      pd_in      = '0;
      sdp_ready  = 1'b0;
      idle(2);
      checkOutput("rst_ready_out", ready_out, 0);
      checkOutput("rst_valid", valid, 0);
      checkOutput("rst_level", buf_level, 0);
      checkOutput("rst_pd", pd, 0);
      checkOutput("rst_elem", elem_cnt, 0);
      checkOutput("rst_batch", batch_cnt, 0);
      checkOutput("rst_layer_done", layer_done, 0);
      clearModel();
      rst = 1'b0;
      idle(1);
      checkOutput("ready_after_rst", ready_out, 1);
      monitor_en = 1'b1;
   endtask

   // Watchdog so the run always ends on its own.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      valid_in  = 1'b0;
      pd_in     = '0;
      sdp_ready = 1'b0;

      // Three elements with SDP always ready: one cycle latency each.
      $display("[TB] test: basic push of three elements");
      resetDut();
      sdp_ready = 1'b1;
      applyStimulus(32'h11, 1'b0, 1'b0);
      applyStimulus(32'h22, 1'b0, 1'b0);
      applyStimulus(32'h33, 1'b0, 1'b0);
      drain();
      idle(1);
      checkOutput("basic_elem_cnt", elem_cnt, 3);
      checkOutput("basic_max_level", max_level, 1);
      checkOutput("basic_latency", last_pop - first_push, 3);

      // Fill to full with SDP stalled, then release.
      $display("[TB] test: fill to full and release");
      resetDut();
      sdp_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) applyStimulus(32'hA0 + i, 1'b0, 1'b0);
      checkOutput("full_level", buf_level, 8);
      checkOutput("full_ready_out", ready_out, 0);
      fork
         applyStimulus(32'hA8, 1'b0, 1'b0);
         begin
            idle(3);
            checkOutput("full_level_held", buf_level, 8);
            checkOutput("full_ready_held", ready_out, 0);
            checkOutput("full_valid", valid, 1);
            sdp_ready = 1'b1;
            @(negedge clk);
            checkOutput("ready_at_first_pop", ready_out, 0);
            @(negedge clk);
            checkOutput("ready_after_first_pop", ready_out, 1);
         end
      join
      drain();
      idle(1);
      checkOutput("full_elem_cnt", elem_cnt, 9);

      // Sustained streaming: 100 elements in 101 cycles.
      $display("[TB] test: stream of 100 elements");
      resetDut();
      sdp_ready = 1'b1;
      for (int i = 0; i < 100; i++) applyStimulus(32'h1000 + i, 1'b0, 1'b0);
      drain();
      idle(1);
      checkOutput("stream_span", last_pop - first_push, 100);
      checkOutput("stream_max_level", max_level, 1);
      checkOutput("stream_elem_cnt", elem_cnt, 100);

      // Markers: batch_end on 10 and 20, layer_end on 30.
      $display("[TB] test: batch and layer markers");
      resetDut();
      sdp_ready = 1'b1;
      for (int i = 1; i <= 10; i++) applyStimulus(i, i == 10, 1'b0);
      drain();
      idle(1);
      checkOutput("mark_batch_10", batch_cnt, 1);
      checkOutput("mark_elem_10", elem_cnt, 10);
      for (int i = 11; i <= 20; i++) applyStimulus(i, i == 20, 1'b0);
      drain();
      idle(1);
      checkOutput("mark_batch_20", batch_cnt, 2);
      checkOutput("mark_elem_20", elem_cnt, 20);
      done_pulses = 0;
      for (int i = 21; i <= 30; i++) applyStimulus(i, 1'b0, i == 30);
      drain();
      idle(2);
      checkOutput("mark_elem_30", elem_cnt, 0);
      checkOutput("mark_batch_30", batch_cnt, 0);
      checkOutput("mark_done_pulses", done_pulses, 1);

      // Both markers on one element: layer_end wins.
      $display("[TB] test: batch_end and layer_end together");
      applyStimulus(32'h55, 1'b1, 1'b0);
      drain();
      idle(1);
      checkOutput("both_pre_batch", batch_cnt, 1);
      checkOutput("both_pre_elem", elem_cnt, 1);
      done_pulses = 0;
      applyStimulus(32'h66, 1'b1, 1'b1);
      drain();
      idle(2);
      checkOutput("both_batch", batch_cnt, 0);
      checkOutput("both_elem", elem_cnt, 0);
      checkOutput("both_done_pulses", done_pulses, 1);

      // Two layer_end elements back to back give two pulses.
      done_pulses = 0;
      applyStimulus(32'h77, 1'b0, 1'b1);
      applyStimulus(32'h88, 1'b0, 1'b1);
      drain();
      idle(2);
      checkOutput("b2b_done_pulses", done_pulses, 2);

      // Reset in the middle of a stream with five elements buffered.
      $display("[TB] test: reset mid-stream");
      resetDut();
      sdp_ready = 1'b1;
      applyStimulus(32'h01, 1'b1, 1'b0);
      applyStimulus(32'h02, 1'b0, 1'b0);
      drain();
      idle(1);
      checkOutput("mid_pre_elem", elem_cnt, 2);
      checkOutput("mid_pre_batch", batch_cnt, 1);
      sdp_ready = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(32'hB0 + i, 1'b0, 1'b0);
      checkOutput("mid_level", buf_level, 5);
      #3;
      monitor_en = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("mid_async_valid", valid, 0);
      checkOutput("mid_async_level", buf_level, 0);
      checkOutput("mid_async_elem", elem_cnt, 0);
      checkOutput("mid_async_batch", batch_cnt, 0);
      checkOutput("mid_async_ready", ready_out, 0);
      checkOutput("mid_async_pd", pd, 0);
      clearModel();
      sdp_ready = 1'b1;
      idle(1);
      checkOutput("mid_ready_in_rst", ready_out, 0);
      rst = 1'b0;
      idle(1);
      checkOutput("mid_ready_after", ready_out, 1);
      checkOutput("mid_valid_after", valid, 0);
      monitor_en = 1'b1;
      idle(5);
      checkOutput("mid_no_stale_valid", valid, 0);
      checkOutput("mid_no_stale_level", buf_level, 0);

      monitor_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
